bit_gather_seq: RTL and testbench

Column-gather sequencer that sits directly upstream of the 8:1 lane mux in DropLator. It accepts bytes on a valid/ready stream, presents each byte to the mux, and steps the mux select through only the lanes enabled by a per-byte keep mask. It samples the mux's single-bit output on each visited lane and packs the kept bits LSB-first into OUT_W-bit words on a valid/ready output stream. This is the bit-level projection step: dropped lanes consume no cycles and no output space.

---
 rtl/droplator_pkg.sv | 13 +
 rtl/lane_next_pe.sv | 21 ++
 rtl/bit_gather_seq.sv | 149 ++++++++++++++
 tb/tb_bit_gather_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/droplator_pkg.sv
// Shared definitions for the DropLator column-gather path.
package droplator_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_e;

endpackage

// File: rtl/lane_next_pe.sv
// Lowest-set-bit priority encoder picking the next lane to visit.
module lane_next_pe
    import droplator_pkg::*;
(
    input  logic [LANES-1:0] req,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |req;
        // Descending scan so the lowest set bit is the final assignment.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bit_gather_seq.sv
// Steps the lane mux through kept lanes of each byte and packs sampled bits LSB-first.
module bit_gather_seq
    import droplator_pkg::*;
#(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = $clog2(OUT_W) + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [LANES-1:0] s_data,
    input  logic [LANES-1:0] s_mask,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [LANES-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic [OUT_W-1:0] m_data,
    output logic [CNT_W-1:0] m_count,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready
);

    state_e state_q, state_d;

    logic             en_q;
    logic [LANES-1:0] mux_in_q, mux_in_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic             last_q, last_d;
    logic [LANES-1:0] visited_q, visited_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [SEL_W-1:0] sel_q;
    logic             pend_q;

    logic [LANES-1:0] pend_vec;
    logic [SEL_W-1:0] nxt_idx;
    logic             nxt_any;
    logic             accept;
    logic             step;
    logic [CNT_W-1:0] fill_inc;
    logic             full;

    assign accept   = s_valid & s_ready;
    assign step     = (state_q == SCAN) & pend_q;
    assign fill_inc = fill_q + CNT_W'(1);
    assign full     = (fill_inc == CNT_W'(OUT_W));

    // Encoder looks at next-cycle lane state so the select can be registered.
    assign pend_vec = mask_d & ~visited_d;

    lane_next_pe u_pe (
        .req (pend_vec),
        .idx (nxt_idx),
        .any (nxt_any)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (step && full) begin
                    state_d = EMIT;
                end else if (!nxt_any) begin
                    state_d = last_q ? EMIT : IDLE;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    state_d = pend_q ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = en_q & (state_q == IDLE);
        m_valid = (state_q == EMIT);
        m_data  = m_valid ? acc_q : '0;
        m_count = m_valid ? fill_q : '0;
        m_last  = m_valid & last_q & ~pend_q;
        mux_in  = mux_in_q;
        mux_sel = sel_q;
    end

    always_comb begin
        mux_in_d  = mux_in_q;
        mask_d    = mask_q;
        last_d    = last_q;
        visited_d = visited_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        if (accept) begin
            mux_in_d  = s_data;
            mask_d    = s_mask;
            last_d    = s_last;
            visited_d = '0;
        end
        if (step) begin
            acc_d     = acc_q | (OUT_W'(mux_out) << fill_q);
            fill_d    = fill_inc;
            visited_d = visited_q | (LANES'(1) << sel_q);
        end
        if ((state_q == EMIT) && m_ready) begin
            acc_d  = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en_q      <= 1'b0;
            mux_in_q  <= '0;
            mask_q    <= '0;
            last_q    <= 1'b0;
            visited_q <= '0;
            acc_q     <= '0;
            fill_q    <= '0;
            sel_q     <= '0;
            pend_q    <= 1'b0;
        end else begin
            en_q      <= 1'b1;
            mux_in_q  <= mux_in_d;
            mask_q    <= mask_d;
            last_q    <= last_d;
            visited_q <= visited_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            sel_q     <= nxt_idx;
            pend_q    <= nxt_any;
        end
    end

endmodule

// File: tb/tb_bit_gather_seq.sv
// Directed bench for bit_gather_seq with OUT_W=8 and a behavioural lane mux.
module tb_bit_gather_seq;

    localparam int unsigned OUT_W = 8;
    localparam int unsigned CNT_W = $clog2(OUT_W) + 1;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [CNT_W-1:0] count;
        logic             last;
    } beat_t;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [7:0]       s_data = '0;
    logic [7:0]       s_mask = '0;
    logic             s_last = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       mux_in;
    logic [2:0]       mux_sel;
    logic             mux_out;
    logic [OUT_W-1:0] m_data;
    logic [CNT_W-1:0] m_count;
    logic             m_last;
    logic             m_valid;
    logic             m_ready = 1'b1;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t exp_q[$];

    bit_gather_seq #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  (s_data),
        .s_mask  (s_mask),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .mux_in  (mux_in),
        .mux_sel (mux_sel),
        .mux_out (mux_out),
        .m_data  (m_data),
        .m_count (m_count),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    assign mux_out = mux_in[mux_sel];

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [OUT_W-1:0] d, input int c, input logic l);
        beat_t b;
        b.data  = d;
        b.count = CNT_W'(c);
        b.last  = l;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] m, input logic l);
        int n;
        s_data  = d;
        s_mask  = m;
        s_last  = l;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        chk("s_ready_wait", 32'(s_ready), 1);
        @(posedge aclk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!(s_ready && !m_valid && exp_q.size() == 0) && n < 500);
        chk("idle_reached", 32'(s_ready), 1);
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask

    // Scoreboard: every output handshake pops one expected beat.
    always @(negedge aclk) begin
        if (aresetn && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(m_valid), 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", 32'(m_data), 32'(e.data));
                chk("beat_count", 32'(m_count), 32'(e.count));
                chk("beat_last", 32'(m_last), 32'(e.last));
            end
        end
    end

    initial begin
        int cnt;
        beat_t snap;

        // Reset state
        #2;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_count", 32'(m_count), 0);
        chk("rst_mux_in", 32'(mux_in), 0);
        chk("rst_mux_sel", 32'(mux_sel), 0);
        #20 aresetn = 1'b1;
        #1 chk("s_ready_before_edge", 32'(s_ready), 0);
        @(negedge aclk);
        chk("s_ready_after_edge", 32'(s_ready), 1);

        // Upper-nibble mask, single-byte record
        push_exp(8'h0A, 4, 1'b1);
        send(8'hA5, 8'hF0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("scan_sel_f0", 32'(mux_sel), 32'(4 + i));
        end
        wait_idle();

        // Two full bytes, exact fill on last byte: no trailing empty beat
        push_exp(8'hFF, 8, 1'b0);
        push_exp(8'h00, 8, 1'b1);
        send(8'hFF, 8'hFF, 1'b0);
        send(8'h00, 8'hFF, 1'b1);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("no_third_beat", 32'(m_valid), 0);
        end

        // Zero mask closing a record with empty accumulator
        push_exp(8'h00, 0, 1'b1);
        send(8'h5A, 8'h00, 1'b1);
        wait_idle();

        // Back-to-back zero masks without last: one busy cycle each, no beat
        for (int k = 0; k < 2; k++) begin
            send(8'h33, 8'h00, 1'b0);
            cnt = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge aclk);
                if (s_ready) break;
                cnt++;
            end
            chk("zero_mask_busy", 32'(cnt), 1);
            chk("zero_mask_no_beat", 32'(m_valid), 0);
        end

        // Backpressure mid-byte: word fills on lane 3, lanes 4..7 still pending
        m_ready = 1'b0;
        push_exp(8'h6F, 8, 1'b0);
        push_exp(8'h0B, 4, 1'b1);
        send(8'h0F, 8'h0F, 1'b0);
        send(8'hB6, 8'hFF, 1'b1);
        cnt = 0;
        while (!m_valid && cnt < 50) begin
            @(negedge aclk);
            cnt++;
        end
        chk("emit_reached", 32'(m_valid), 1);
        snap.data  = 8'h6F;
        snap.count = CNT_W'(8);
        snap.last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge aclk);
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data", 32'(m_data), 32'(snap.data));
            chk("hold_count", 32'(m_count), 32'(snap.count));
            chk("hold_last", 32'(m_last), 32'(snap.last));
            chk("hold_sel", 32'(mux_sel), 4);
        end
        @(posedge aclk);
        #1 m_ready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("resume_sel", 32'(mux_sel), 4);
        chk("resume_scan", 32'(m_valid), 0);
        wait_idle();

        // Reset mid-scan after three appends discards partial word
        send(8'hFF, 8'h0F, 1'b1);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b0;
        #1;
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_m_data", 32'(m_data), 0);
        chk("mid_rst_m_count", 32'(m_count), 0);
        chk("mid_rst_m_last", 32'(m_last), 0);
        chk("mid_rst_mux_in", 32'(mux_in), 0);
        chk("mid_rst_mux_sel", 32'(mux_sel), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        push_exp(8'h01, 1, 1'b1);
        send(8'h01, 8'h01, 1'b1);
        wait_idle();

        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
